issue_queue: RTL and testbench

- Per-FU reservation station between dispatch and one functional unit. One instance each for ALU, branch and LSU.
- Buffers renamed micro-ops and snoops the three CDB writeback ports to wake source operands.
- Selects the oldest fully-ready entry by ROB age and hands it to the FU with a valid/ready handshake.
- Squashes entries younger than a mispredicted branch.

---
 rtl/issue_queue_pkg.sv | 29 ++
 rtl/iq_age_select.sv | 34 +++
 rtl/issue_queue.sv | 129 ++++++++++++
 tb/tb_issue_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared processor types for the reservation-station slice.
// Micro-op bundle, CDB/tag widths and ROB age helper.
package issue_queue_pkg;

  localparam int PREG_W    = 7;
  localparam int ROB_TAG_W = 5;
  localparam int NUM_CDB   = 3;
  localparam int OP_W      = 4;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [PREG_W-1:0]    pd;
    logic [PREG_W-1:0]    ps1;
    logic                 ps1_rdy;
    logic [PREG_W-1:0]    ps2;
    logic                 ps2_rdy;
    logic [31:0]          imm;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          pc;
  } rs_data;

  function automatic logic [ROB_TAG_W-1:0] rob_age(
    input logic [ROB_TAG_W-1:0] tag,
    input logic [ROB_TAG_W-1:0] head
  );
    return tag - head;
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Oldest-ready picker: smallest ROB age among eligible entries.
// Tags are unique, so a strict compare never sees a tie.
module iq_age_select
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                elig_i,
  input  logic [DEPTH-1:0][ROB_TAG_W-1:0] tag_i,
  input  logic [ROB_TAG_W-1:0]            head_i,
  output logic                            valid_o,
  output logic [IW-1:0]                   idx_o
);

  logic [ROB_TAG_W-1:0] best_age;
  logic [ROB_TAG_W-1:0] cur_age;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    best_age = '1;
    cur_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cur_age = rob_age(tag_i[i], head_i);
      if (elig_i[i] && (!valid_o || cur_age < best_age)) begin
        valid_o  = 1'b1;
        idx_o    = IW'(i);
        best_age = cur_age;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Per-FU reservation station: CDB wakeup, oldest-ready issue,
// and squash of entries younger than a mispredicted branch.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  rs_data                            in_data,
  output logic                              in_ready,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB-1:0][PREG_W-1:0]    cdb_preg,
  input  logic [ROB_TAG_W-1:0]              rob_head,
  input  logic                              mispredict,
  input  logic [ROB_TAG_W-1:0]              mispredict_tag,
  output logic                              issue_valid,
  output rs_data                            issue_data,
  input  logic                              fu_ready,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rs_data [DEPTH-1:0]              ent_q, ent_d;
  logic   [DEPTH-1:0]              vld_q, vld_d;
  logic   [CW-1:0]                 count_q, count_d;
  logic   [DEPTH-1:0]              elig;
  logic   [DEPTH-1:0][ROB_TAG_W-1:0] tags;
  logic                            sel_vld;
  logic   [IW-1:0]                 sel_idx;
  logic                            free_ok;
  logic   [IW-1:0]                 free_idx;
  logic                            do_ins;
  logic                            do_issue;
  logic   [ROB_TAG_W-1:0]          kill_age;

  function automatic logic woken(
    input logic [PREG_W-1:0]               p,
    input logic [NUM_CDB-1:0]              v,
    input logic [NUM_CDB-1:0][PREG_W-1:0]  pr
  );
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < NUM_CDB; c++)
      if (v[c] && pr[c] == p) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = vld_q[i] & ent_q[i].ps1_rdy & ent_q[i].ps2_rdy;
      tags[i] = ent_q[i].rob_tag;
    end
  end

  iq_age_select #(.DEPTH(DEPTH), .IW(IW)) u_sel (
    .elig_i  (elig),
    .tag_i   (tags),
    .head_i  (rob_head),
    .valid_o (sel_vld),
    .idx_o   (sel_idx)
  );

  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign in_ready    = count_q < CW'(DEPTH);
  assign count       = count_q;
  assign issue_valid = sel_vld & ~mispredict;
  assign issue_data  = issue_valid ? ent_q[sel_idx] : '0;
  assign do_issue    = issue_valid & fu_ready;
  assign do_ins      = in_valid & in_ready & free_ok & ~mispredict;
  assign kill_age    = rob_age(mispredict_tag, rob_head);

  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        if (woken(ent_q[i].ps1, cdb_valid, cdb_preg))
          ent_d[i].ps1_rdy = 1'b1;
        if (woken(ent_q[i].ps2, cdb_valid, cdb_preg))
          ent_d[i].ps2_rdy = 1'b1;
        if (mispredict &&
            rob_age(ent_q[i].rob_tag, rob_head) > kill_age)
          vld_d[i] = 1'b0;
      end
    end
    if (do_issue) vld_d[sel_idx] = 1'b0;
    // Same-cycle CDB hit at insert avoids a lost wakeup.
    if (do_ins) begin
      ent_d[free_idx] = in_data;
      ent_d[free_idx].ps1_rdy = in_data.ps1_rdy
        | (in_data.ps1 == '0)
        | woken(in_data.ps1, cdb_valid, cdb_preg);
      ent_d[free_idx].ps2_rdy = in_data.ps2_rdy
        | (in_data.ps2 == '0)
        | woken(in_data.ps2, cdb_valid, cdb_preg);
      vld_d[free_idx] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++)
      count_d = count_d + CW'(vld_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q   <= '0;
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: vector table plus
// hand sequences, issue order checked against a tag scoreboard.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           in_valid;
  rs_data                         in_data;
  logic                           in_ready;
  logic [NUM_CDB-1:0]             cdb_valid;
  logic [NUM_CDB-1:0][PREG_W-1:0] cdb_preg;
  logic [ROB_TAG_W-1:0]           rob_head;
  logic                           mispredict;
  logic [ROB_TAG_W-1:0]           mispredict_tag;
  logic                           issue_valid;
  rs_data                         issue_data;
  logic                           fu_ready;
  logic [3:0]                     count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    int tag;
    int exp_count;
    int exp_tag;
  } vec_t;
  vec_t vecs[3];

  issue_queue #(.DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .cdb_valid      (cdb_valid),
    .cdb_preg       (cdb_preg),
    .rob_head       (rob_head),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .issue_valid    (issue_valid),
    .issue_data     (issue_data),
    .fu_ready       (fu_ready),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted issue must match the next expected tag.
  always @(negedge clk) begin
    if (!reset && issue_valid === 1'b1 && fu_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got tag %0d expected none",
                 issue_data.rob_tag);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (32'(issue_data.rob_tag) !== 32'(e)) begin
          errors++;
          $display("FAIL issue_order: got tag %0d expected %0d",
                   issue_data.rob_tag, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int tag, input int p1, input int r1,
                        input int p2, input int r2);
    in_data         = '0;
    in_data.op      = OP_W'(tag);
    in_data.pd      = PREG_W'(tag + 40);
    in_data.rob_tag = ROB_TAG_W'(tag);
    in_data.ps1     = PREG_W'(p1);
    in_data.ps1_rdy = r1[0];
    in_data.ps2     = PREG_W'(p2);
    in_data.ps2_rdy = r2[0];
    in_data.pc      = 32'(tag * 4);
  endtask

  task automatic ins(input int tag, input int p1, input int r1,
                     input int p2, input int r2);
    set_op(tag, p1, r1, p2, r2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    step();
    fu_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++)
      @(negedge clk);
    step();
    fu_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0",
               nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_data        = '0;
    cdb_valid      = '0;
    cdb_preg       = '0;
    rob_head       = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
    fu_ready       = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_issue_data", 32'(issue_data != '0), 0);

    // CDB wakeup, issue the cycle after the broadcast.
    step();
    ins(7, 5, 0, 0, 0);
    @(negedge clk);
    chk("wk_count", 32'(count), 1);
    chk("wk_not_ready", 32'(issue_valid), 0);
    step();
    cdb_valid   = 3'b001;
    cdb_preg[0] = PREG_W'(5);
    fu_ready    = 1'b1;
    exp_q.push_back(7);
    @(negedge clk);
    chk("wk_same_cycle", 32'(issue_valid), 0);
    step();
    cdb_valid = '0;
    @(negedge clk);
    chk("wk_issue", 32'(issue_valid), 1);
    step();
    fu_ready = 1'b0;
    @(negedge clk);
    chk("wk_count_after", 32'(count), 0);

    // Wrap-around age order, stalled FU.
    vecs[0] = '{30, 1, 30};
    vecs[1] = '{31, 2, 30};
    vecs[2] = '{1, 3, 30};
    step();
    rob_head = ROB_TAG_W'(30);
    for (int i = 0; i < 3; i++) begin
      ins(vecs[i].tag, 0, 1, 0, 1);
      @(negedge clk);
      chk($sformatf("age_count_%0d", i), 32'(count),
          32'(vecs[i].exp_count));
      chk($sformatf("age_valid_%0d", i), 32'(issue_valid), 1);
      chk($sformatf("age_tag_%0d", i), 32'(issue_data.rob_tag),
          32'(vecs[i].exp_tag));
    end
    exp_q.push_back(30);
    exp_q.push_back(31);
    exp_q.push_back(1);
    drain("age");
    @(negedge clk);
    chk("age_count_end", 32'(count), 0);

    // Full queue refuses insert even while issuing.
    step();
    rob_head = '0;
    for (int i = 0; i < 8; i++) ins(i, 0, 1, 0, 1);
    @(negedge clk);
    chk("full_count", 32'(count), 8);
    chk("full_in_ready", 32'(in_ready), 0);
    step();
    set_op(20, 0, 1, 0, 1);
    in_valid = 1'b1;
    fu_ready = 1'b1;
    exp_q.push_back(0);
    @(negedge clk);
    chk("full_busy", 32'(in_ready), 0);
    step();
    in_valid = 1'b0;
    fu_ready = 1'b0;
    @(negedge clk);
    chk("full_count_7", 32'(count), 7);
    chk("full_ready_again", 32'(in_ready), 1);
    for (int i = 1; i < 8; i++) exp_q.push_back(i);
    drain("full");
    @(negedge clk);
    chk("full_count_end", 32'(count), 0);
    chk("full_idle", 32'(issue_valid), 0);

    // Insert-time CDB bypass on ps2.
    step();
    cdb_valid   = 3'b101;
    cdb_preg[0] = PREG_W'(33);
    cdb_preg[2] = PREG_W'(9);
    ins(10, 3, 1, 9, 0);
    cdb_valid = '0;
    @(negedge clk);
    chk("byp_issue", 32'(issue_valid), 1);
    chk("byp_ps2_rdy", 32'(issue_data.ps2_rdy), 1);
    chk("byp_tag", 32'(issue_data.rob_tag), 10);
    exp_q.push_back(10);
    drain("byp");

    // Mispredict squash of younger entries.
    step();
    rob_head = ROB_TAG_W'(2);
    ins(6, 0, 1, 0, 1);
    ins(3, 0, 1, 0, 1);
    ins(7, 0, 1, 0, 1);
    ins(4, 0, 1, 0, 1);
    set_op(5, 0, 1, 0, 1);
    in_valid       = 1'b1;
    mispredict     = 1'b1;
    mispredict_tag = ROB_TAG_W'(4);
    fu_ready       = 1'b1;
    @(negedge clk);
    chk("flush_no_issue", 32'(issue_valid), 0);
    step();
    in_valid   = 1'b0;
    mispredict = 1'b0;
    fu_ready   = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 2);
    chk("flush_oldest", 32'(issue_data.rob_tag), 3);
    exp_q.push_back(3);
    exp_q.push_back(4);
    drain("flush");
    @(negedge clk);
    chk("flush_count_end", 32'(count), 0);

    // Reset mid-operation with an insert offered.
    step();
    rob_head = '0;
    for (int i = 0; i < 5; i++) ins(i, 0, 1, 0, 1);
    @(negedge clk);
    chk("mrst_pre_count", 32'(count), 5);
    step();
    reset = 1'b1;
    set_op(9, 0, 1, 0, 1);
    in_valid = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_issue_valid", 32'(issue_valid), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d pending expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
